// File: rtl/depth_test.sv
// Z-buffer depth test: strict less-than compare against an on-chip depth
// memory, 3-cycle fixed-latency pipeline with one-level write forwarding.
module depth_test #(
  parameter int          SCREEN_W = 320,
  parameter int          SCREEN_H = 240,
  parameter logic [15:0] FAR_Z    = 16'hFFFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_in,
  input  logic        valid_in,
  input  logic [8:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [15:0] z_in,
  input  logic [11:0] rgb_in,
  output logic        ready_out,
  output logic        valid_out,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic [15:0] z_out,
  output logic [11:0] rgb_out,
  output logic [15:0] pass_count
);

  localparam int          NPIX = SCREEN_W * SCREEN_H;
  localparam logic [16:0] LAST = 17'(NPIX - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic        v;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
    logic [11:0] rgb;
  } frag_t;

  state_t      state, state_nx;
  logic [16:0] clr_addr, clr_addr_nx;

  frag_t       s0, s1, s2, s2_d, s3;
  logic [16:0] s1_a, s2_a;

  logic        accept, in_range, hit, s1_pass, we;
  logic [16:0] in_addr, rd_addr, wa;
  logic [15:0] wd, rd_q, stored;

  logic [15:0] mem [NPIX];

  assign ready_out = (state == RUN);
  assign accept    = valid_in && ready_out && !clear_in;
  assign in_range  = (32'(x_in) < SCREEN_W) &&
                     (32'(y_in) < SCREEN_H);
  assign in_addr   = 17'(y_in) * 17'(SCREEN_W)
                   + 17'(x_in);
  assign rd_addr   = in_range ? in_addr : '0;

  assign s0 = '{v:   accept && in_range,
                x:   x_in,
                y:   y_in,
                z:   z_in,
                rgb: rgb_in};

  // s2 holds only passed fragments, whose write landed
  // on the same edge s1's read was taken
  assign hit     = s2.v && (s2_a == s1_a);
  assign stored  = hit ? s2.z : rd_q;
  assign s1_pass = s1.v && (s1.z < stored);

  always_comb begin
    s2_d   = s1;
    s2_d.v = s1_pass;
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    if (clear_in) begin
      state_nx    = CLEAR;
      clr_addr_nx = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_addr == LAST) begin
            state_nx    = RUN;
            clr_addr_nx = '0;
          end else begin
            clr_addr_nx = clr_addr + 17'd1;
          end
        end
        RUN: ;
      endcase
    end
  end

  always_comb begin
    we = 1'b0;
    wa = s1_a;
    wd = s1.z;
    if (state == CLEAR) begin
      we = !rst_in;
      wa = clr_addr;
      wd = FAR_Z;
    end else if (s1_pass && !clear_in && !rst_in) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (we) mem[wa] <= wd;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      s1.v <= 1'b0;
      s2.v <= 1'b0;
      s3.v <= 1'b0;
    end else begin
      s1   <= s0;
      s1_a <= in_addr;
      s2   <= s2_d;
      s2_a <= s1_a;
      s3   <= s2;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      rgb_out    <= '0;
      pass_count <= '0;
    end else if (clear_in) begin
      valid_out  <= 1'b0;
      pass_count <= '0;
    end else begin
      valid_out <= s3.v;
      x_out     <= s3.x;
      y_out     <= s3.y;
      z_out     <= s3.z;
      rgb_out   <= s3.rgb;
      if (s3.v && pass_count != 16'hFFFF)
        pass_count <= pass_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_depth_test.sv
// Directed bench for depth_test on a reduced 40x24 screen so each
// clear takes 960 cycles; outputs tracked through a 3-deep expectation pipe.
module tb_depth_test;

  localparam int W  = 40;
  localparam int H  = 24;
  localparam int NP = W * H;

  logic        clk = 1'b0;
  logic        rst, clr, vin;
  logic [8:0]  xi;
  logic [7:0]  yi;
  logic [15:0] zi;
  logic [11:0] ci;
  logic        ready_out, valid_out;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic [15:0] z_out;
  logic [11:0] rgb_out;
  logic [15:0] pass_count;

  always #5 clk = ~clk;

  depth_test #(
    .SCREEN_W(W),
    .SCREEN_H(H),
    .FAR_Z(16'hFFFF)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .clear_in(clr),
    .valid_in(vin),
    .x_in(xi),
    .y_in(yi),
    .z_in(zi),
    .rgb_in(ci),
    .ready_out(ready_out),
    .valid_out(valid_out),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .rgb_out(rgb_out),
    .pass_count(pass_count)
  );

  typedef struct {
    logic        v;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] z;
    logic [11:0] rgb;
  } exp_t;

  exp_t        e [4];
  exp_t        cur;
  int          nchk  = 0;
  int          npass = 0;
  int          n;
  int          mcount;
  logic [15:0] zb [64];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 3; i > 0; i--) e[i] = e[i-1];
    e[0] = cur;
    chk("valid_out", valid_out, e[3].v);
    if (e[3].v) begin
      chk("x_out", x_out, e[3].x);
      chk("y_out", y_out, e[3].y);
      chk("z_out", z_out, e[3].z);
      chk("rgb_out", rgb_out, e[3].rgb);
    end
  endtask

  task automatic send(input logic [8:0] x,
                      input logic [7:0] y,
                      input logic [15:0] z,
                      input logic [11:0] c,
                      input logic p);
    xi  = x;
    yi  = y;
    zi  = z;
    ci  = c;
    vin = 1'b1;
    cur = '{v: p, x: x, y: y, z: z, rgb: c};
    step();
    vin   = 1'b0;
    cur.v = 1'b0;
  endtask

  task automatic kill_pipe();
    for (int i = 0; i < 4; i++) e[i].v = 1'b0;
    cur.v = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready_out && cnt < 2 * NP) begin
      cnt++;
      step();
    end
  endtask

  task automatic do_clear();
    kill_pipe();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    vin = 1'b0;
    xi  = '0;
    yi  = '0;
    zi  = '0;
    ci  = '0;
    cur = '{v: 1'b0, x: '0, y: '0, z: '0, rgb: '0};
    for (int i = 0; i < 4; i++) e[i] = cur;

    step();
    step();
    chk("rst_ready", ready_out, 0);
    chk("rst_pc", pass_count, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_z", z_out, 0);
    chk("rst_rgb", rgb_out, 0);

    rst = 1'b0;
    wait_ready(n);
    chk("clear_cycles", n, NP);
    chk("ready_after_clear", ready_out, 1);
    chk("pc_after_clear", pass_count, 0);

    send(9'd10, 8'd20, 16'h1000, 12'hF00, 1'b1);
    step();
    step();
    step();
    send(9'd10, 8'd20, 16'h2000, 12'h0A0, 1'b0);
    send(9'd10, 8'd20, 16'h1000, 12'h0B0, 1'b0);
    send(9'd10, 8'd20, 16'h0800, 12'h00C, 1'b1);
    repeat (4) step();
    chk("pc_basic", pass_count, 2);

    send(9'd5, 8'd5, 16'h3000, 12'h111, 1'b1);
    send(9'd5, 8'd5, 16'h2000, 12'h222, 1'b1);
    send(9'd5, 8'd5, 16'h2800, 12'h333, 1'b0);
    send(9'd5, 8'd5, 16'h1000, 12'h444, 1'b1);
    repeat (4) step();
    chk("pc_fwd", pass_count, 5);

    send(9'd40, 8'd0, 16'h0000, 12'h555, 1'b0);
    send(9'd0, 8'd24, 16'h0000, 12'h666, 1'b0);
    repeat (4) step();
    chk("pc_oob", pass_count, 5);
    send(9'd39, 8'd23, 16'h0001, 12'h777, 1'b1);
    repeat (4) step();
    chk("pc_corner", pass_count, 6);

    send(9'd7, 8'd7, 16'h0100, 12'h888, 1'b1);
    send(9'd7, 8'd7, 16'h0080, 12'h999, 1'b1);
    do_clear();
    chk("ready_drop", ready_out, 0);
    wait_ready(n);
    chk("abort_clear_cycles", n, NP);
    chk("pc_abort", pass_count, 0);
    send(9'd7, 8'd7, 16'hFFFE, 12'hABC, 1'b1);
    send(9'd8, 8'd8, 16'hFFFF, 12'hDEF, 1'b0);
    repeat (4) step();
    chk("pc_far", pass_count, 1);

    do_clear();
    wait_ready(n);
    chk("rand_clear_cycles", n, NP);
    for (int i = 0; i < 64; i++) zb[i] = 16'hFFFF;
    mcount = 0;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [8:0]  rx;
        logic [7:0]  ry;
        logic [15:0] rz;
        logic        p;
        rx = 9'($urandom_range(0, 7));
        ry = 8'($urandom_range(0, 7));
        rz = 16'($urandom_range(0, 1023));
        p  = rz < zb[ry * 8 + rx];
        if (p) begin
          zb[ry * 8 + rx] = rz;
          mcount++;
        end
        send(rx, ry, rz, 12'($urandom), p);
      end else begin
        step();
      end
    end
    repeat (4) step();
    chk("pc_random", pass_count, mcount);

    kill_pipe();
    rst = 1'b1;
    clr = 1'b1;
    vin = 1'b1;
    xi  = 9'd1;
    yi  = 8'd1;
    zi  = 16'h0000;
    step();
    chk("rst_prio_ready", ready_out, 0);
    chk("rst_prio_pc", pass_count, 0);
    rst = 1'b0;
    clr = 1'b0;
    vin = 1'b0;
    repeat (4) step();
    chk("rst_prio_ready2", ready_out, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/depth_test.md
DEPTH_TEST -- requirements
Module: depth_test

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 240, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter FAR_Z, default 16'hFFFF, meaning the depth value written on clear.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_in (input, 1, gpu clock) and rst_in (input, 1, sync active-high reset).
REQ-005 SHALL have clear_in  input  1  one-cycle pulse requesting a depth-buffer clear.
REQ-006 SHALL have valid_in  input  1  fragment valid from fragment_shader.
REQ-007 SHALL have x_in  input  9, y_in  input  8, z_in  input  16, rgb_in  input  12; these are fragment coordinates, depth and colour.
REQ-008 SHALL have ready_out  output  1  high when valid_in is accepted.
REQ-009 SHALL have valid_out  output  1, x_out  output  9, y_out  output  8, z_out  output  16, rgb_out  output  12; these carry the surviving fragment to framebuffer.
REQ-010 SHALL have pass_count  output  16  number of fragments passed since the last clear completed.

Function
REQ-011 SHALL hold an internal depth memory of SCREEN_W*SCREEN_H 16-bit words; address = y*SCREEN_W + x (17-bit).
REQ-012 SHALL implement FSM states CLEAR and RUN; CLEAR -> RUN after the final address is written; RUN -> CLEAR on clear_in.
REQ-013 In CLEAR, SHALL write FAR_Z to one address per cycle, counter 0..SCREEN_W*SCREEN_H-1 (76800 cycles default); ready_out=0 throughout.
REQ-014 In RUN, ready_out SHALL be 1; a fragment is accepted when valid_in && ready_out.
REQ-015 SHALL drop an accepted fragment with x_in>=SCREEN_W or y_in>=SCREEN_H (no memory access, no output).
REQ-016 SHALL pass a fragment iff z_in < stored depth (strict; equal depth rejected; smaller = nearer).
REQ-017 On pass, SHALL write z_in to the depth memory and assert valid_out with the fragment's x, y, z, rgb unchanged.
REQ-018 Latency SHALL be fixed at 3 cycles: accepted at edge N -> valid_out high for one cycle after edge N+3; throughput 1 fragment/cycle.
REQ-019 The stored depth compared SHALL reflect every write by earlier-accepted fragments, including fragments 1 and 2 cycles ahead at the same address (forwarding required).
REQ-020 Output order SHALL equal acceptance order; rejected fragments leave gaps (valid_out=0), no reordering.
REQ-021 clear_in in RUN SHALL abort in-flight fragments (no valid_out for them, no writes) and restart the clear from address 0.
REQ-022 clear_in in CLEAR SHALL restart the clear counter at address 0.
REQ-023 pass_count SHALL increment per passed fragment, saturate at 16'hFFFF, and reset to 0 on entering CLEAR.
REQ-024 When valid_out=0, x_out/y_out/z_out/rgb_out are don't-care.

Reset
REQ-025 On rst_in, SHALL enter CLEAR at address 0, drop all in-flight fragments; valid_out=0, ready_out=0, pass_count=0, x_out=0, y_out=0, z_out=0, rgb_out=0.
REQ-026 rst_in SHALL take priority over clear_in and valid_in in the same cycle.

Verification
REQ-027 Reset, then count cycles -> ready_out=0 for exactly 76800 cycles, then 1; pass_count=0.
REQ-028 After clear, fragment (10,20,z=0x1000,rgb=0xF00) -> valid_out 3 cycles later with identical fields; then (10,20,0x2000) -> rejected; then (10,20,0x1000) -> rejected (equal); then (10,20,0x0800) -> passes; pass_count=2.
REQ-029 Back-to-back same address, consecutive cycles, z=0x3000, 0x2000, 0x2800, 0x1000 -> outputs pass, pass, reject, pass (forwarding check).
REQ-030 Fragments (320,0) and (0,240) -> no valid_out, pass_count unchanged; (319,239,0x0001) -> passes.
REQ-031 Pulse clear_in with 2 fragments in flight -> neither emerges, ready_out drops next cycle for 76800 cycles, pass_count=0; same address then passes at z=0xFFFE.
REQ-032 Random stream of 10000 fragments over 8x8 region vs golden z-buffer model -> valid_out sequence and final pass_count match exactly.
